// File: rtl/sd_deser_pkg.sv
// Shared helpers for the sd_deser narrow-to-wide deserializer.
// Holds the lane index sizing and the lane write-enable decode.
package sd_deser_pkg;

   localparam int unsigned MaxRatio = 32;

   // Wide enough to index any lane of the largest supported ratio.
   typedef logic [$clog2(MaxRatio)-1:0] lane_idx_t;

   function automatic int unsigned idx_width(input int unsigned ratio);
      return (ratio > 1) ? $clog2(ratio) : 1;
   endfunction

   function automatic logic [MaxRatio-1:0] onehot(input lane_idx_t cnt);
      return {{(MaxRatio-1){1'b0}}, 1'b1} << cnt;
   endfunction

endpackage

// File: rtl/sd_deser.sv
// Narrow-to-wide srdy/drdy deserializer: packs ratio beats into one registered wide word.
// Define SD_DESER_LAST_EN to add early word close (c_last) with p_last/p_mask outputs.
module sd_deser
   import sd_deser_pkg::*;
#(
   parameter int unsigned width = 8,
   parameter int unsigned ratio = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   c_srdy,
   output logic                   c_drdy,
   input  logic [width-1:0]       c_data,
`ifdef SD_DESER_LAST_EN
   input  logic                   c_last,
   output logic                   p_last,
   output logic [ratio-1:0]       p_mask,
`endif
   output logic                   p_srdy,
   input  logic                   p_drdy,
   output logic [width*ratio-1:0] p_data
);

   localparam int unsigned IdxW = idx_width(ratio);
   localparam int unsigned Lanes = ratio - 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(ratio - 1);

   logic [IdxW-1:0]        cnt;
   logic [width*Lanes-1:0] asm_data;
   logic [Lanes-1:0]       lane_en;
   logic [width*ratio-1:0] word;
   logic                   accept;
   logic                   close;
`ifdef SD_DESER_LAST_EN
   logic [ratio-1:0]       mask;
`endif

   always_comb begin
`ifdef SD_DESER_LAST_EN
      // Any lane may close, so the last lane can be freed by a same-cycle pop.
      c_drdy = !p_srdy | p_drdy;
      accept = c_srdy & c_drdy;
      close  = accept & ((cnt == LastIdx) | c_last);
`else
      c_drdy = (cnt != LastIdx) | !p_srdy;
      accept = c_srdy & c_drdy;
      close  = accept & (cnt == LastIdx);
`endif
      lane_en = Lanes'(onehot(lane_idx_t'(cnt)));
   end

   // Outgoing word: assembled lanes below cnt, current beat at cnt, zeros above.
   always_comb begin
      word = '0;
      for (int i = 0; i < int'(Lanes); i++) begin
         if (i == int'(cnt)) begin
            word[i*width +: width] = c_data;
         end else if (i < int'(cnt)) begin
            word[i*width +: width] = asm_data[i*width +: width];
         end
      end
      if (cnt == LastIdx) begin
         word[width*Lanes +: width] = c_data;
      end
   end

`ifdef SD_DESER_LAST_EN
   always_comb begin
      mask = '0;
      for (int i = 0; i < int'(ratio); i++) begin
         mask[i] = (i <= int'(cnt));
      end
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt      <= '0;
         asm_data <= '0;
         p_srdy   <= 1'b0;
         p_data   <= '0;
`ifdef SD_DESER_LAST_EN
         p_last   <= 1'b0;
         p_mask   <= '0;
`endif
      end else begin
         if (accept && !close) begin
            for (int i = 0; i < int'(Lanes); i++) begin
               if (lane_en[i]) begin
                  asm_data[i*width +: width] <= c_data;
               end
            end
            cnt <= cnt + 1'b1;
         end
         if (close) begin
            p_data <= word;
            p_srdy <= 1'b1;
            cnt    <= '0;
`ifdef SD_DESER_LAST_EN
            p_last <= c_last;
            p_mask <= mask;
`endif
         end else if (p_srdy && p_drdy) begin
            p_srdy <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sd_deser.sv
// Self-checking bench for sd_deser (width=8, ratio=4): vector table plus hand sequences.
// Covers the SD_DESER_LAST_EN ports when that macro is defined.
module tb_sd_deser;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        c_srdy = 1'b0;
   logic        c_drdy;
   logic [7:0]  c_data = 8'h00;
   logic        p_srdy;
   logic        p_drdy = 1'b0;
   logic [31:0] p_data;
`ifdef SD_DESER_LAST_EN
   logic        c_last = 1'b0;
   logic        p_last;
   logic [3:0]  p_mask;
`endif

   int n_checks = 0;
   int n_fail = 0;

   // Reference model: beats packed in arrival order, completed words queued until popped.
   logic [31:0] sb_q[$];
   logic [31:0] partial = '0;
   int          nbeats = 0;

   int          beat = 0;
   int          last_beat = 0;
   int          accepted = 0;

   typedef struct {
      logic        c_srdy;
      logic [7:0]  c_data;
      logic        p_drdy;
      logic        e_c_drdy;
      logic        e_p_srdy;
      logic [31:0] e_p_data;
   } vec_t;

   vec_t vecs[$];
   logic [31:0] stream_words[4];

   always #5 clk = ~clk;

   sd_deser #(
      .width(8),
      .ratio(4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .c_srdy(c_srdy),
      .c_drdy(c_drdy),
      .c_data(c_data),
`ifdef SD_DESER_LAST_EN
      .c_last(c_last),
      .p_last(p_last),
      .p_mask(p_mask),
`endif
      .p_srdy(p_srdy),
      .p_drdy(p_drdy),
      .p_data(p_data)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called at a negedge with inputs set; advances one clock and updates the model.
   task automatic step();
      logic        acc;
      logic        pop;
      logic        hold;
      logic        lst;
      logic [31:0] held;
      acc  = c_srdy & c_drdy;
      pop  = p_srdy & p_drdy;
      hold = p_srdy & !p_drdy;
      held = p_data;
      lst  = 1'b0;
`ifdef SD_DESER_LAST_EN
      lst  = c_last;
`endif
      if (pop) begin
         if (sb_q.size() == 0) check("sb_underflow", sb_q.size(), 1);
         else check("pop_data", p_data, sb_q.pop_front());
      end
      if (acc) begin
         partial[nbeats*8 +: 8] = c_data;
         nbeats++;
         if (nbeats == 4 || lst) begin
            sb_q.push_back(partial);
            partial = '0;
            nbeats  = 0;
         end
      end
      @(posedge clk);
      @(negedge clk);
      if (hold) begin
         check("hold_p_srdy", p_srdy, 1);
         check("hold_p_data", p_data, held);
      end
   endtask

   task automatic send(input logic [7:0] d);
      int waited = 0;
      c_srdy = 1'b1;
      c_data = d;
      while (!c_drdy && waited < 20) begin
         step();
         waited++;
      end
      if (!c_drdy) check("send_timeout", c_drdy, 1);
      step();
      c_srdy = 1'b0;
   endtask

   // Offers beats beat..last_beat, one per cycle, for a fixed number of cycles.
   task automatic feed(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         c_srdy = (beat <= last_beat);
         c_data = 8'(beat);
         if (c_srdy && c_drdy) begin
            beat++;
            accepted++;
         end
         step();
      end
      c_srdy = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      stream_words = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
      // Basic word
      vecs.push_back('{1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 32'h00000000});
      vecs.push_back('{1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 32'h00000000});
      vecs.push_back('{1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 32'h00000000});
      vecs.push_back('{1'b1, 8'h04, 1'b1, 1'b1, 1'b0, 32'h00000000});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h04030201});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h04030201});
      // Streaming 00..0F: a word is visible for one cycle in every 4-cycle slot
      for (int s = 0; s < 16; s++) begin
         vecs.push_back('{1'b1, 8'(s), 1'b1, 1'b1, (s >= 4 && s % 4 == 0),
                          (s < 4) ? 32'h04030201 : stream_words[s/4 - 1]});
      end
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h0F0E0D0C});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0F0E0D0C});

      // Reset state
      repeat (2) @(negedge clk);
      check("reset_p_srdy", p_srdy, 0);
      check("reset_p_data", p_data, 0);
      check("reset_cnt", 32'(dut.cnt), 0);
`ifdef SD_DESER_LAST_EN
      check("reset_p_last", p_last, 0);
      check("reset_p_mask", p_mask, 0);
`endif
      reset = 1'b0;
      @(negedge clk);
      check("idle_c_drdy", c_drdy, 1);

      foreach (vecs[i]) begin
         c_srdy = vecs[i].c_srdy;
         c_data = vecs[i].c_data;
         p_drdy = vecs[i].p_drdy;
         check($sformatf("vec%0d_c_drdy", i), c_drdy, vecs[i].e_c_drdy);
         check($sformatf("vec%0d_p_srdy", i), p_srdy, vecs[i].e_p_srdy);
         check($sformatf("vec%0d_p_data", i), p_data, vecs[i].e_p_data);
         step();
      end
      c_srdy = 1'b0;

      // Backpressure: word 20..23 held, then only three more beats fit
      p_drdy    = 1'b0;
      beat      = 'h20;
      last_beat = 'h2B;
      accepted  = 0;
      feed(12);
      check("bp_accepted", accepted, 7);
      check("bp_c_drdy", c_drdy, 0);
      check("bp_p_srdy", p_srdy, 1);
      check("bp_p_data", p_data, 32'h23222120);
      p_drdy = 1'b1;
      feed(1);
      p_drdy = 1'b0;
      feed(6);
      check("bp2_accepted", accepted, 11);
      check("bp2_p_srdy", p_srdy, 1);
      check("bp2_p_data", p_data, 32'h27262524);
      p_drdy = 1'b1;
      feed(20);
      check("bp_all_beats", beat, 'h2C);
      repeat (3) step();
      check("bp_drained", sb_q.size(), 0);

      // Reset mid-word with a held word pending
      p_drdy = 1'b0;
      send(8'h60);
      send(8'h61);
      send(8'h62);
      send(8'h63);
      send(8'hAA);
      send(8'hBB);
      check("pre_rst_p_srdy", p_srdy, 1);
      check("pre_rst_cnt", 32'(dut.cnt), 2);
      #2 reset = 1'b1;
      #1;
      check("rst_p_srdy", p_srdy, 0);
      check("rst_p_data", p_data, 0);
      check("rst_cnt", 32'(dut.cnt), 0);
      sb_q.delete();
      partial = '0;
      nbeats  = 0;
      @(negedge clk);
      reset  = 1'b0;
      p_drdy = 1'b1;
      @(negedge clk);
      send(8'h11);
      send(8'h22);
      send(8'h33);
      send(8'h44);
      check("post_rst_p_srdy", p_srdy, 1);
      check("post_rst_p_data", p_data, 32'h44332211);
      step();
      check("post_rst_popped", p_srdy, 0);

`ifdef SD_DESER_LAST_EN
      // Early close at lane 1
      p_drdy = 1'b0;
      send(8'hAA);
      c_last = 1'b1;
      send(8'hBB);
      c_last = 1'b0;
      check("last_p_data", p_data, 32'h0000BBAA);
      check("last_p_mask", p_mask, 4'b0011);
      check("last_p_last", p_last, 1);
      check("last_cnt", 32'(dut.cnt), 0);
      p_drdy = 1'b1;
      send(8'h01);
      send(8'h02);
      send(8'h03);
      send(8'h04);
      check("full_p_data", p_data, 32'h04030201);
      check("full_p_mask", p_mask, 4'b1111);
      check("full_p_last", p_last, 0);
      step();
`endif

      check("sb_empty", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
